// File: rtl/pclk_pkg.sv
// ============================================================
// pclk_pkg : shared types and helpers for the power-clock sequencer
// Rev 1.0
// ============================================================
`default_nettype none

package pclk_pkg;

  localparam int NPH = 4;

  typedef enum logic [1:0] {
    PH_RAMPUP = 2'd0,
    PH_HOLD   = 2'd1,
    PH_RAMPDN = 2'd2,
    PH_WAIT   = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fsm_t;

  // Phase k lags the global quarter by k quarters.
  function automatic phase_t phase_of(input logic [1:0] q, input logic [1:0] k);
    return phase_t'(q - k);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pclk_phase_gen_if.sv
// ============================================================
// pclk_phase_gen_if : run request and power-clock rail outputs
// Rev 1.0
// ============================================================
`default_nettype none

interface pclk_phase_gen_if #(
  parameter int LVL_W = 3,
  parameter int CNT_W = 16
);

  logic                 run;
  logic                 busy;
  logic                 done;
  logic [1:0]           quarter;
  logic [CNT_W-1:0]     cyc_cnt;
  logic [4*LVL_W-1:0]   clkpos_lvl;
  logic [4*LVL_W-1:0]   clkneg_lvl;
  logic [3:0]           clkpos;
  logic [3:0]           clkneg;

  modport master (
    output run,
    input  busy, done, quarter, cyc_cnt, clkpos_lvl, clkneg_lvl, clkpos, clkneg
  );

  modport slave (
    input  run,
    output busy, done, quarter, cyc_cnt, clkpos_lvl, clkneg_lvl, clkpos, clkneg
  );

endinterface

`default_nettype wire

// File: rtl/pclk_phase_lvl.sv
// ============================================================
// pclk_phase_lvl : registered trapezoid level and rail bits for one phase
// Rev 1.0
// ============================================================
`default_nettype none

module pclk_phase_lvl import pclk_pkg::*; #(
  parameter int LVL_W = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  phase_t           ps,
  input  logic [LVL_W-1:0] step,
  input  logic             act,
  output logic [LVL_W-1:0] lvl,
  output logic [LVL_W-1:0] lvl_n,
  output logic             pos,
  output logic             neg
);

  localparam logic [LVL_W-1:0] C_MAX = '1;

  logic [LVL_W-1:0] w_lvl;

  always_comb begin
    w_lvl = '0;
    if (act) begin
      case (ps)
        PH_RAMPUP: w_lvl = step + LVL_W'(1);
        PH_HOLD:   w_lvl = C_MAX;
        PH_RAMPDN: w_lvl = C_MAX - LVL_W'(1) - step;
        default:   w_lvl = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lvl   <= '0;
      lvl_n <= C_MAX;
      pos   <= 1'b0;
      neg   <= 1'b1;
    end else begin
      lvl   <= w_lvl;
      lvl_n <= C_MAX - w_lvl;
      pos   <= (w_lvl == C_MAX);
      neg   <= (w_lvl != C_MAX);
    end
  end

endmodule

`default_nettype wire

// File: rtl/pclk_phase_gen.sv
// ============================================================
// pclk_phase_gen : four-phase power-clock sequencer with gated start and drain
// Rev 1.0
// ============================================================
`default_nettype none

module pclk_phase_gen import pclk_pkg::*; #(
  parameter int LVL_W = 3,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rstn,
  pclk_phase_gen_if.slave    bus
);

  localparam logic [LVL_W-1:0] C_LAST = {LVL_W{1'b1}} - LVL_W'(1);

  fsm_t              r_state;
  logic              r_stop;
  logic [1:0]        r_q;
  logic [LVL_W-1:0]  r_step;
  logic [NPH-1:0]    r_active;
  logic              r_busy;
  logic              r_done;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_start;
  logic              w_stop;
  logic              w_bnd;
  logic [1:0]        w_q_nxt;
  logic [LVL_W-1:0]  w_step_nxt;
  logic [NPH-1:0]    w_active_nxt;

  logic [NPH*LVL_W-1:0] w_pos_lvl;
  logic [NPH*LVL_W-1:0] w_neg_lvl;
  logic [NPH-1:0]       w_pos;
  logic [NPH-1:0]       w_neg;

  // Next-state timing; level registers sample these so outputs track the new quarter/step.
  always_comb begin
    w_start      = (r_state == ST_IDLE) && bus.run;
    w_stop       = r_stop || ((r_state == ST_RUN) && !bus.run);
    w_bnd        = (r_state != ST_IDLE) && (r_step == C_LAST);
    w_q_nxt      = r_q;
    w_step_nxt   = r_step;
    w_active_nxt = r_active;
    if (w_start) begin
      w_q_nxt      = 2'd0;
      w_step_nxt   = '0;
      w_active_nxt = NPH'(1);
    end else if (r_state != ST_IDLE) begin
      if (w_bnd) begin
        w_step_nxt = '0;
        w_q_nxt    = r_q + 2'd1;
        for (int k = 0; k < NPH; k++) begin
          if (w_stop) begin
            // Draining: retire phases entering WAIT and block any restart.
            if (phase_of(w_q_nxt, 2'(k)) == PH_WAIT || phase_of(w_q_nxt, 2'(k)) == PH_RAMPUP)
              w_active_nxt[k] = 1'b0;
          end else if (k != 0 && w_q_nxt == 2'(k)) begin
            w_active_nxt[k] = 1'b1;
          end
        end
      end else begin
        w_step_nxt = r_step + LVL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_stop   <= 1'b0;
      r_q      <= 2'd0;
      r_step   <= '0;
      r_active <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_q      <= w_q_nxt;
      r_step   <= w_step_nxt;
      r_active <= w_active_nxt;
      r_busy   <= |w_active_nxt;
      r_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.run) begin
            r_state <= ST_RUN;
            r_stop  <= 1'b0;
            r_cnt   <= '0;
          end
        end
        ST_RUN: begin
          if (!bus.run) begin
            r_state <= ST_DRAIN;
            r_stop  <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_active_nxt == '0) begin
            r_state <= ST_IDLE;
            r_stop  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // Phase 0 leaving RAMPDN marks one completed period.
      if (w_bnd && r_q == 2'd2 && r_active[0] && r_cnt != {CNT_W{1'b1}})
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  generate
    for (genvar g = 0; g < NPH; g++) begin : g_phase
      pclk_phase_lvl #(.LVL_W(LVL_W)) u_lvl (
        .clk   (clk),
        .rstn  (rstn),
        .ps    (phase_of(w_q_nxt, 2'(g))),
        .step  (w_step_nxt),
        .act   (w_active_nxt[g]),
        .lvl   (w_pos_lvl[g*LVL_W +: LVL_W]),
        .lvl_n (w_neg_lvl[g*LVL_W +: LVL_W]),
        .pos   (w_pos[g]),
        .neg   (w_neg[g])
      );
    end
  endgenerate

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.quarter    = r_q;
  assign bus.cyc_cnt    = r_cnt;
  assign bus.clkpos_lvl = w_pos_lvl;
  assign bus.clkneg_lvl = w_neg_lvl;
  assign bus.clkpos     = w_pos;
  assign bus.clkneg     = w_neg;

endmodule

`default_nettype wire
